maxpool1d_stream: RTL and testbench
===================================

Name: maxpool1d_stream

Overview:
- Streaming 1-D max-pool stage that consumes the rectified activation stream leaving the ReLU threshold stage of the CNN seizure-detection datapath.
- Takes one signed 16-bit sample per accepted beat and emits the maximum of each non-overlapping window of POOL samples.
- Valid/ready on both sides; feeds the next convolution layer's input buffer.
- A frame-end marker closes a partial window early so EEG frames of any length pool correctly.

Parameters:
- DATA_W, 16, sample width, two's complement.
- POOL, 2, window length and stride; legal range 2..16.
- CNT_W, 4, window counter width; must satisfy 2^CNT_W >= POOL.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  global enable; low freezes all state, and in_ready is forced to 0.
- in_data  in  DATA_W  activation sample, signed.
- in_valid  in  1  in_data is valid.
- in_last  in  1  qualifies the final sample of a frame.
- in_ready  out  1  sink can accept a sample this cycle.
- out_data  out  DATA_W  pooled maximum, signed.
- out_valid  out  1  out_data is valid.
- out_last  out  1  this result closes a frame.
- out_ready  in  1  downstream accepts out_data.
- out_idx  out  CNT_W  position of the maximum within its window (present only with ARGMAX_OUT_EN).

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-low. While rst=0:
  - out_data=0, out_valid=0, out_last=0, out_idx=0.
  - Window count=0, running max cleared.
  - in_ready=0.
  - Deassertion takes effect on the first clk edge with rst=1.
- Accept: a sample is accepted when in_valid & in_ready & en.
- Emit: an output is taken when out_valid & out_ready.
- in_ready = en & ~(out_valid & ~out_ready & closing), where closing = (cnt==POOL-1) | in_last.
  - Non-closing samples are always accepted while en=1, even when the output is stalled.
- States:
  - ACCUM: cnt in 0..POOL-1. Accepting at cnt=0 loads max=in_data, idx=0.
  - Accepting at cnt>0 replaces max only when in_data > max (signed strict compare). Ties keep the earliest position.
  - CLOSE: an accepted closing sample goes through the same compare. The result is registered to out_data/out_idx with out_valid=1 on the next edge, so latency from the closing sample to out_valid is 1 cycle. out_last=in_last. cnt returns to 0.
- Back-to-back operation: when the output is taken and a new closing sample is accepted in the same cycle, out_valid stays 1 and out_data updates to the new result. There is no bubble.
- out_valid drop: out_valid falls after a take only when no new result is being written.
- Partial window: in_last at cnt<POOL-1 emits the max of the cnt+1 samples received. A single-sample window outputs that sample.
- Stall hold: out_data, out_last and out_idx are held stable while out_valid=1 and out_ready=0.
- en=0: cnt, max, the output register and out_valid all freeze. out_valid stays asserted if already set, but a take is ignored until en returns to 1.
- Arithmetic: comparison is signed over the full DATA_W bits. Negative inputs (possible if the ReLU stage is bypassed) pool correctly. No saturation, no width growth.
- Reset mid-window: the partial window is discarded, and a pending output is dropped.

Optional Feature:
- Macro: ARGMAX_OUT_EN.
- Defined: out_idx port exists and carries the 0-based position of the retained maximum. It is registered with out_data and follows the same hold rules.
- Not defined: no out_idx port and no idx register. All other behaviour is identical.

Test Plan:
- Reset sequence: hold rst=0 for 3 cycles, then release -> all outputs 0, in_ready=0 during reset, in_ready=1 on the first cycle after release with en=1.
- Basic pooling: POOL=2, stream 5,9,3,3,0,7 with in_last on 7, out_ready=1 -> outputs 9,3,7 each 1 cycle after the pair's second sample; out_last=1 only on 7; out_idx 1,0,1.
- Partial window: POOL=4, stream 2,8,1 with in_last on 1 -> single output 8, out_last=1, out_idx=1; next frame starts at cnt=0.
- Backpressure: POOL=2, out_ready=0 after the first result 9 -> next non-closing sample accepted; in_ready=0 on the closing sample; out_data stays 9 until out_ready=1, then the new max appears the next cycle with no sample lost.
- Signed and ties: POOL=3, inputs 0xFFF0,0x8000,0xFFF0 -> output 0xFFF0 with out_idx=0.
- Enable and mid-stream reset: en=0 for 4 cycles mid-window -> no accept, state frozen, output resumes correctly afterwards. rst pulse with cnt=1 and a pending output -> out_valid=0 immediately; the next window result contains only post-reset samples.

Source files
------------

// File: rtl/maxpool1d_stream.sv
// maxpool1d_stream: streaming 1-D max-pool with valid/ready handshakes on both sides.
// Emits the signed maximum of each non-overlapping window of POOL samples.
// in_last_i closes a partial window early so frames of any length pool correctly.
// Optional build macro ARGMAX_OUT_EN adds out_idx_o, the 0-based position of the
// retained maximum inside its window.
module maxpool1d_stream #(
    parameter int DATA_W = 16,
    parameter int POOL   = 2,
    parameter int CNT_W  = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_valid_i,
    input  logic              in_last_i,
    output logic              in_ready_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    output logic              out_last_o,
    input  logic              out_ready_i
`ifdef ARGMAX_OUT_EN
    ,
    output logic [CNT_W-1:0]  out_idx_o
`endif
);

    // Window state
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] max_q, max_d;
    // Output register
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    // Set on the first edge after reset release; keeps in_ready low while in reset
    logic              active_q;

    logic              closing;
    logic              accept;
    logic              take;
    logic              in_ready;
    logic [DATA_W-1:0] cand_max;
    logic              cand_new;

`ifdef ARGMAX_OUT_EN
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  out_idx_q, out_idx_d;
    logic [CNT_W-1:0]  cand_idx;
`endif

    // Handshake decode and running-max candidate including the current sample
    always_comb begin
        closing  = (cnt_q == CNT_W'(POOL - 1)) | in_last_i;
        // A closing sample needs the output register free (empty or being taken now)
        in_ready = active_q & en_i & ~(out_valid_q & ~out_ready_i & closing);
        accept   = in_valid_i & in_ready;
        take     = en_i & out_valid_q & out_ready_i;
        // First sample of a window loads unconditionally; later ones only on strict
        // signed greater-than so ties keep the earliest position
        cand_new = (cnt_q == '0) | ($signed(in_data_i) > $signed(max_q));
        cand_max = cand_new ? in_data_i : max_q;
`ifdef ARGMAX_OUT_EN
        cand_idx = cand_new ? cnt_q : idx_q;
`endif
    end

    // Next-state: accumulate, close a window into the output register, or drain it
    always_comb begin
        cnt_d       = cnt_q;
        max_d       = max_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
`ifdef ARGMAX_OUT_EN
        idx_d       = idx_q;
        out_idx_d   = out_idx_q;
`endif
        // A take with no new result frees the output register
        if (take) begin
            out_valid_d = 1'b0;
        end
        if (accept) begin
            if (closing) begin
                // Register the window result; overrides the take for back-to-back flow
                out_data_d  = cand_max;
                out_valid_d = 1'b1;
                out_last_d  = in_last_i;
                cnt_d       = '0;
`ifdef ARGMAX_OUT_EN
                out_idx_d   = cand_idx;
`endif
            end else begin
                max_d = cand_max;
                cnt_d = cnt_q + CNT_W'(1);
`ifdef ARGMAX_OUT_EN
                idx_d = cand_idx;
`endif
            end
        end
    end

    // State registers with asynchronous active-low reset; en_i low blocks every
    // update through accept/take being forced low
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q    <= 1'b0;
            cnt_q       <= '0;
            max_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
`ifdef ARGMAX_OUT_EN
            idx_q       <= '0;
            out_idx_q   <= '0;
`endif
        end else begin
            active_q    <= 1'b1;
            cnt_q       <= cnt_d;
            max_q       <= max_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
`ifdef ARGMAX_OUT_EN
            idx_q       <= idx_d;
            out_idx_q   <= out_idx_d;
`endif
        end
    end

    assign in_ready_o  = in_ready;
    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;
    assign out_last_o  = out_last_q;
`ifdef ARGMAX_OUT_EN
    assign out_idx_o   = out_idx_q;
`endif

endmodule

// File: tb/tb_maxpool1d_stream.sv
// Self-checking bench for maxpool1d_stream (POOL=3). Each step drives one cycle of
// inputs; a window-queue model computes expected in_ready and pooled outputs.
module tb_maxpool1d_stream;

    localparam int DW = 16;
    localparam int P  = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_last;
    logic          out_ready;
`ifdef ARGMAX_OUT_EN
    logic [CW-1:0] out_idx;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: samples of the open window plus the expected output register
    logic [DW-1:0] win[$];
    bit            m_active;
    bit            m_valid;
    logic [DW-1:0] m_data;
    bit            m_last;
    int            m_idx;

    always #5 clk = ~clk;

    maxpool1d_stream #(.DATA_W(DW), .POOL(P), .CNT_W(CW)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .en_i       (en),
        .in_data_i  (in_data),
        .in_valid_i (in_valid),
        .in_last_i  (in_last),
        .in_ready_o (in_ready),
        .out_data_o (out_data),
        .out_valid_o(out_valid),
        .out_last_o (out_last),
        .out_ready_i(out_ready)
`ifdef ARGMAX_OUT_EN
        ,
        .out_idx_o  (out_idx)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Max over the window queue, earliest position wins ties
    task automatic pool_window(input bit last);
        m_data = win[0];
        m_idx  = 0;
        for (int i = 1; i < win.size(); i++) begin
            if ($signed(win[i]) > $signed(m_data)) begin
                m_data = win[i];
                m_idx  = i;
            end
        end
        m_valid = 1'b1;
        m_last  = last;
    endtask

    task automatic check_outputs(input string ctx);
        chk({ctx, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            chk({ctx, ".out_data"}, 32'(out_data), 32'(m_data));
            chk({ctx, ".out_last"}, 32'(out_last), 32'(m_last));
`ifdef ARGMAX_OUT_EN
            chk({ctx, ".out_idx"}, 32'(out_idx), 32'(m_idx));
`endif
        end
    endtask

    // One clock cycle of stimulus with model update and checks
    task automatic step(input logic v, input logic [DW-1:0] d, input logic l,
                        input logic ordy, input logic e, input string ctx);
        bit exp_rdy, acc, tk;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = ordy;
        en        = e;
        #1;
        exp_rdy = m_active && e && !(m_valid && !ordy && ((win.size() == P - 1) || l));
        chk({ctx, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
        acc = v && exp_rdy;
        tk  = e && m_valid && ordy;
        @(posedge clk);
        if (tk) m_valid = 1'b0;
        if (acc) begin
            win.push_back(d);
            if (l || win.size() == P) begin
                pool_window(l);
                win.delete();
            end
        end
        #1;
        check_outputs(ctx);
        $display("step %-8s v=%0d d=%04h l=%0d ordy=%0d en=%0d acc=%0d -> ov=%0d od=%04h ol=%0d",
                 ctx, v, d, l, ordy, e, acc, out_valid, out_data, out_last);
    endtask

    // Asynchronous reset held for n falling edges; model state discarded
    task automatic reset_pulse(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        win.delete();
        m_active = 1'b0;
        m_valid  = 1'b0;
        #1;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.out_data", 32'(out_data), 32'd0);
        chk("rst.out_last", 32'(out_last), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd0);
`ifdef ARGMAX_OUT_EN
        chk("rst.out_idx", 32'(out_idx), 32'd0);
`endif
        for (int i = 1; i < n; i++) begin
            @(negedge clk);
            #1;
            chk("rst.in_ready_hold", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        m_active = 1'b1;
        $display("reset released after %0d cycles", n);
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = 1'b1;
        in_data   = '0;
        in_valid  = 1'b1;
        in_last   = 1'b0;
        out_ready = 1'b1;
        m_active  = 1'b0;
        m_valid   = 1'b0;
        m_data    = '0;
        m_last    = 1'b0;
        m_idx     = 0;

        // Reset sequence
        reset_pulse(3);

        // Basic pooling: full windows, then a frame closed on the final full window
        step(1, 16'd5, 0, 1, 1, "basic");
        step(1, 16'd9, 0, 1, 1, "basic");
        step(1, 16'd3, 0, 1, 1, "basic");
        step(1, 16'd3, 0, 1, 1, "basic");
        step(1, 16'd0, 0, 1, 1, "basic");
        step(1, 16'd7, 1, 1, 1, "basic");
        step(0, 16'd0, 0, 1, 1, "basic");

        // Partial windows: two samples, then a single-sample frame
        step(1, 16'd2, 0, 1, 1, "partial");
        step(1, 16'd8, 1, 1, 1, "partial");
        step(1, 16'd4, 1, 1, 1, "partial");
        step(0, 16'd0, 0, 1, 1, "partial");

        // Signed compare and ties
        step(1, 16'hFFF0, 0, 1, 1, "signed");
        step(1, 16'h8000, 0, 1, 1, "signed");
        step(1, 16'hFFF0, 0, 1, 1, "signed");
        step(0, 16'd0, 0, 1, 1, "signed");

        // Backpressure: non-closing samples flow, closing sample waits for the take
        step(1, 16'd5, 0, 1, 1, "bp");
        step(1, 16'd9, 0, 1, 1, "bp");
        step(1, 16'd3, 0, 0, 1, "bp");
        step(1, 16'd4, 0, 0, 1, "bp");
        step(1, 16'd6, 0, 0, 1, "bp");
        step(1, 16'd8, 0, 0, 1, "bp");
        step(1, 16'd8, 0, 0, 1, "bp");
        step(1, 16'd8, 0, 1, 1, "bp");
        step(0, 16'd0, 0, 1, 1, "bp");

        // Enable low with a pending output and a half-filled window
        step(1, 16'd1, 0, 0, 1, "en");
        step(1, 16'd7, 0, 0, 1, "en");
        step(1, 16'd2, 0, 0, 1, "en");
        step(1, 16'd10, 0, 0, 1, "en");
        for (int i = 0; i < 4; i++) step(1, 16'd99, 0, 1, 0, "en_off");
        step(1, 16'd3, 0, 1, 1, "en");
        step(1, 16'd20, 0, 1, 1, "en");
        step(0, 16'd0, 0, 1, 1, "en");

        // Mid-stream reset with a pending output and cnt=1
        step(1, 16'd1, 0, 0, 1, "midrst");
        step(1, 16'd2, 0, 0, 1, "midrst");
        step(1, 16'd3, 0, 0, 1, "midrst");
        step(1, 16'd50, 0, 0, 1, "midrst");
        reset_pulse(2);
        step(1, 16'd6, 0, 1, 1, "postrst");
        step(1, 16'd5, 0, 1, 1, "postrst");
        step(1, 16'd1, 0, 1, 1, "postrst");
        step(0, 16'd0, 0, 1, 1, "postrst");

        // Randomized traffic with frequent ties, negatives, stalls and enable drops
        for (int i = 0; i < 400; i++) begin
            logic [DW-1:0] rd;
            rd = ($urandom_range(0, 1) == 0) ? DW'($urandom) : DW'($urandom_range(0, 3));
            step($urandom_range(0, 3) != 0, rd, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 9) != 0, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
